// File: rtl/wt_cache_pkg.sv
// Shared cache constants and the MSHR record used by the write-through dcache miss path.
package wt_cache_pkg;

   localparam int unsigned PLEN                = 34;
   localparam int unsigned CACHE_ID_WIDTH      = 3;
   localparam int unsigned DCACHE_OFFSET_WIDTH = 6;
   localparam int unsigned LINE_WIDTH          = PLEN - DCACHE_OFFSET_WIDTH;

   typedef struct packed {
      logic                      valid;
      logic [LINE_WIDTH-1:0]     line;
      logic [CACHE_ID_WIDTH-1:0] tid;
   } mshr_t;

   // Clears the offset bits so cacheable fills always start on a line boundary.
   function automatic logic [PLEN-1:0] line_align(input logic [PLEN-1:0] paddr);
      return {paddr[PLEN-1:DCACHE_OFFSET_WIDTH], {DCACHE_OFFSET_WIDTH{1'b0}}};
   endfunction

endpackage

// File: rtl/wt_dcache_miss_arb_rr_arb_tree.sv
// Round-robin selector; the search starts at the port after the last one served.
module rr_arb_tree #(
   parameter int unsigned NumIn = 3,
   parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NumIn-1:0] req_i,
   input  logic             adv_i,
   output logic             gnt_vld_o,
   output logic [IdxW-1:0]  idx_o
);

   logic [IdxW-1:0] ptr_q;

   // Descending scan so the candidate closest to the pointer overwrites the others.
   always_comb begin
      gnt_vld_o = 1'b0;
      idx_o     = '0;
      for (int k = int'(NumIn) - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_q) + k) % int'(NumIn)]) begin
            gnt_vld_o = 1'b1;
            idx_o     = IdxW'((int'(ptr_q) + k) % int'(NumIn));
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (adv_i && gnt_vld_o) begin
         ptr_q <= (idx_o == IdxW'(NumIn - 1)) ? '0 : idx_o + IdxW'(1);
      end
   end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Arbitrates dcache read misses onto one memory request port, tracking one MSHR per
// controller so a second miss to an outstanding line is bounced back for replay.
module wt_dcache_miss_arb
   import wt_cache_pkg::*;
#(
   parameter int unsigned NumPorts   = 3,
   parameter int unsigned RdTxIdBase = 1
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [NumPorts-1:0]                      miss_req_i,
   output logic [NumPorts-1:0]                      miss_ack_o,
   output logic [NumPorts-1:0]                      miss_replay_o,
   input  logic [NumPorts-1:0][PLEN-1:0]            miss_paddr_i,
   input  logic [NumPorts-1:0]                      miss_nc_i,
   input  logic [NumPorts-1:0][2:0]                 miss_size_i,
   input  logic [NumPorts-1:0][CACHE_ID_WIDTH-1:0]  miss_id_i,
   output logic [NumPorts-1:0]                      miss_rtrn_vld_o,
   output logic                                     mem_req_o,
   input  logic                                     mem_gnt_i,
   output logic [PLEN-1:0]                          mem_paddr_o,
   output logic                                     mem_nc_o,
   output logic [2:0]                               mem_size_o,
   output logic [CACHE_ID_WIDTH-1:0]                mem_tid_o,
   input  logic                                     mem_rtrn_vld_i,
   input  logic [CACHE_ID_WIDTH-1:0]                mem_rtrn_tid_i
);

   localparam int unsigned IdxW = $clog2(NumPorts);

   if (NumPorts < 2 || NumPorts > 8) begin : g_bad_num_ports
      $error("NumPorts must be within 2..8");
   end
   if (RdTxIdBase + NumPorts > 2 ** CACHE_ID_WIDTH) begin : g_bad_tid_range
      $error("Port transaction ids do not fit in CACHE_ID_WIDTH");
   end

   typedef enum logic {IDLE, REQ} state_e;

   state_e                    state_q;
   mshr_t                     mshr_q [NumPorts];
   logic [IdxW-1:0]           port_q;
   logic [PLEN-1:0]           paddr_q;
   logic                      nc_q;
   logic [2:0]                size_q;
   logic [CACHE_ID_WIDTH-1:0] tid_q;
   logic                      mem_req_q;

   logic                      sel_vld;
   logic [IdxW-1:0]           sel_idx;
   logic [LINE_WIDTH-1:0]     sel_line;
   logic                      collide;
   logic                      select;
   logic                      alloc;

   rr_arb_tree #(
      .NumIn (NumPorts),
      .IdxW  (IdxW)
   ) i_rr_arb_tree (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (miss_req_i),
      .adv_i     (select),
      .gnt_vld_o (sel_vld),
      .idx_o     (sel_idx)
   );

   // Collision check reads the MSHRs before any same-cycle return clears them.
   always_comb begin
      sel_line = miss_paddr_i[sel_idx][PLEN-1:DCACHE_OFFSET_WIDTH];
      collide  = 1'b0;
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (mshr_q[i].valid && (mshr_q[i].line == sel_line)) begin
            collide = 1'b1;
         end
      end
      select = (state_q == IDLE) && sel_vld;
      alloc  = select && !collide;

      miss_replay_o = '0;
      if (select && collide) begin
         miss_replay_o[sel_idx] = 1'b1;
      end

      miss_ack_o = '0;
      if ((state_q == REQ) && mem_gnt_i) begin
         miss_ack_o[port_q] = 1'b1;
      end

      miss_rtrn_vld_o = '0;
      for (int i = 0; i < int'(NumPorts); i++) begin
         miss_rtrn_vld_o[i] = mem_rtrn_vld_i && mshr_q[i].valid && (mshr_q[i].tid == mem_rtrn_tid_i);
      end
   end

   // Return clears come first so an allocation on the same edge takes precedence.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         port_q    <= '0;
         paddr_q   <= '0;
         nc_q      <= 1'b0;
         size_q    <= '0;
         tid_q     <= '0;
         mem_req_q <= 1'b0;
         for (int i = 0; i < int'(NumPorts); i++) begin
            mshr_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NumPorts); i++) begin
            if (miss_rtrn_vld_o[i]) begin
               mshr_q[i].valid <= 1'b0;
            end
         end
         case (state_q)
            IDLE: begin
               if (alloc) begin
                  port_q    <= sel_idx;
                  paddr_q   <= miss_nc_i[sel_idx] ? miss_paddr_i[sel_idx]
                                                  : line_align(miss_paddr_i[sel_idx]);
                  nc_q      <= miss_nc_i[sel_idx];
                  size_q    <= miss_size_i[sel_idx];
                  tid_q     <= miss_id_i[sel_idx];
                  mem_req_q <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  mshr_q[port_q].valid <= 1'b1;
                  mshr_q[port_q].line  <= paddr_q[PLEN-1:DCACHE_OFFSET_WIDTH];
                  mshr_q[port_q].tid   <= tid_q;
                  mem_req_q            <= 1'b0;
                  state_q              <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_paddr_o = paddr_q;
   assign mem_nc_o    = nc_q;
   assign mem_size_o  = size_q;
   assign mem_tid_o   = tid_q;

endmodule

// File: doc/wt_dcache_miss_arb.md
WT_DCACHE_MISS_ARB -- requirements
Module: wt_dcache_miss_arb

Interface
REQ-001 Parameter: NumPorts, default 3, number of dcache read controllers served (2..8).
REQ-002 Parameter: RdTxIdBase, default 1, miss_id of port 0; port i uses RdTxIdBase+i.
REQ-003 clk_i  in  1  clock; one clock, all logic rising-edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 miss_req_i  in  NumPorts  per-port miss request, held until ack or replay.
REQ-006 miss_ack_o  out  NumPorts  one-cycle pulse: request accepted by memory.
REQ-007 miss_replay_o  out  NumPorts  one-cycle pulse: line collides with pending miss, controller replays.
REQ-008 miss_paddr_i  in  NumPorts x riscv::PLEN  request physical address.
REQ-009 miss_nc_i  in  NumPorts  non-cacheable request.
REQ-010 miss_size_i  in  NumPorts x 3  size; 3'b111 = cacheline.
REQ-011 miss_id_i  in  NumPorts x CACHE_ID_WIDTH  transaction id per port.
REQ-012 miss_rtrn_vld_o  out  NumPorts  one-cycle pulse: miss of that port served.
REQ-013 mem_req_o  out  1  request to memory; held until mem_gnt_i.
REQ-014 mem_gnt_i  in  1  memory accepts request this cycle.
REQ-015 mem_paddr_o / mem_nc_o / mem_size_o / mem_tid_o  out  PLEN / 1 / 3 / CACHE_ID_WIDTH  request fields.
REQ-016 mem_rtrn_vld_i  in  1  response valid; mem_rtrn_tid_i  in  CACHE_ID_WIDTH  response id.

Function
REQ-017 One MSHR per port: valid bit, line address paddr[PLEN-1:DCACHE_OFFSET_WIDTH], tid.
REQ-018 FSM states IDLE and REQ; no other state.
REQ-019 IDLE: round-robin select among asserted miss_req_i, starting after last selected port; none -> stay IDLE.
REQ-020 IDLE, selected line equals any valid MSHR line (nc included): miss_replay_o pulse to selected port same cycle, stay IDLE, advance RR pointer.
REQ-021 IDLE, no collision: latch port, paddr, nc, size, id into request register; go REQ; advance RR pointer.
REQ-022 REQ: mem_req_o=1, mem_* driven from request register, stable until gnt.
REQ-023 REQ with mem_gnt_i: miss_ack_o pulse to latched port, set its MSHR valid, go IDLE same edge.
REQ-024 Minimum latency miss_req_i to miss_ack_o: 1 cycle (select cycle, then gnt in REQ); throughput one request per 2 cycles.
REQ-025 mem_paddr_o: full address if nc; cacheline-aligned (offset bits zero) otherwise.
REQ-026 mem_rtrn_vld_i: MSHR whose tid equals mem_rtrn_tid_i cleared at edge; miss_rtrn_vld_o pulse to that port same cycle.
REQ-027 Return tid matching no valid MSHR: ignored, no pulse, no state change.
REQ-028 Return and collision check same cycle on same line: check uses pre-clear MSHR state (replay).
REQ-029 Return and allocation same cycle: both applied; different ports by construction.
REQ-030 miss_req_i deasserted while in REQ: request still completes and MSHR allocated (controller tracks in KILL_MISS).
REQ-031 At most one of miss_ack_o, miss_replay_o asserted per cycle across all ports.

Reset
REQ-032 rst_i asserted: state IDLE, RR pointer port 0, all MSHR invalid, request register zero.
REQ-033 All outputs 0 during and after reset until first request.
REQ-034 Reset mid-REQ drops request; returns arriving after reset for pre-reset tids ignored per REQ-027.

Structure
REQ-035 CACHE_ID_WIDTH, DCACHE_OFFSET_WIDTH, MSHR struct typedef in wt_cache_pkg.
REQ-036 FSM state enum local to module.
REQ-037 Round-robin selection via existing rr_arb_tree sub-module; no other sub-modules.

Verification
REQ-038 Port 0 req paddr 0x8000_1040 cacheable, gnt immediate -> mem_paddr_o 0x8000_1040, size 3'b111, ack port 0 cycle 1; rtrn tid 1 -> miss_rtrn_vld_o[0].
REQ-039 Port 0 pending 0x8000_1040; port 1 req 0x8000_1078 -> miss_replay_o[1] pulse, no mem_req_o.
REQ-040 Ports 0,1,2 req simultaneously, distinct lines, gnt immediate -> acks order 0,1,2 on cycles 1,3,5.
REQ-041 Port 2 nc req 0x1000_0004 size 2'b10, gnt delayed 4 cycles -> mem fields stable, ack on gnt cycle, paddr unaligned.
REQ-042 rtrn tid 7 unmatched -> no pulse; rst_i mid-REQ -> mem_req_o 0 next cycle, MSHRs cleared.
